// File: rtl/rom_custom.sv
// rom_custom: fixed 16 x 8 lookup table (bit masks, test patterns)
// registered read port with valid strobe and even-parity bit
module rom_custom #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity
);

  logic [DATA_W-1:0] rom_byte;
  logic [DATA_W-1:0] data_d, data_q;
  logic              par_d, par_q;
  logic              valid_d, valid_q;

  // constant table as pure decode logic, no storage
  always_comb begin
    rom_byte = '0;
    case (addr)
      4'h0: rom_byte = 8'h01;
      4'h1: rom_byte = 8'h02;
      4'h2: rom_byte = 8'h04;
      4'h3: rom_byte = 8'h08;
      4'h4: rom_byte = 8'h10;
      4'h5: rom_byte = 8'h20;
      4'h6: rom_byte = 8'h40;
      4'h7: rom_byte = 8'h80;
      4'h8: rom_byte = 8'hFF;
      4'h9: rom_byte = 8'hAA;
      4'hA: rom_byte = 8'h55;
      4'hB: rom_byte = 8'h0F;
      4'hC: rom_byte = 8'hF0;
      4'hD: rom_byte = 8'h3C;
      4'hE: rom_byte = 8'hC3;
      4'hF: rom_byte = 8'h00;
      default: rom_byte = '0;
    endcase
  end

  // load byte and parity on a read, hold them when idle
  always_comb begin
    data_d  = data_q;
    par_d   = par_q;
    valid_d = 1'b0;
    if (en) begin
      data_d  = rom_byte;
      par_d   = ^rom_byte;
      valid_d = 1'b1;
    end
  end

  // output registers, cleared at once by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      par_q   <= par_d;
      valid_q <= valid_d;
    end
  end

  assign data_out = data_q;
  assign parity   = par_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_rom_custom.sv
// tb_rom_custom: scoreboard bench for rom_custom
// directed plan items plus randomized reads and reset pulses
module tb_rom_custom;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] addr;
  logic [7:0] data_out;
  logic       valid;
  logic       parity;

  int nchk;
  int nerr;

  byte unsigned rom_m [16] = '{
    8'h01, 8'h02, 8'h04, 8'h08,
    8'h10, 8'h20, 8'h40, 8'h80,
    8'hFF, 8'hAA, 8'h55, 8'h0F,
    8'hF0, 8'h3C, 8'hC3, 8'h00
  };

  byte unsigned exp_q [$];
  logic         iss;
  int           rst_cnt;

  rom_custom #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .addr     (addr),
    .data_out (data_out),
    .valid    (valid),
    .parity   (parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit even_par(input byte unsigned b);
    return ($countones(b) % 2) == 1;
  endfunction

  // scoreboard producer: record every issued read
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      iss = 1'b0;
      rst_cnt++;
    end else begin
      iss = en;
      if (en) exp_q.push_back(rom_m[addr]);
    end
  end

  // monitor: sample 1 ns after each edge and compare
  initial begin
    byte unsigned hold;
    byte unsigned e;
    int seen;
    hold = 8'h00;
    seen = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_cnt != seen) begin
        seen = rst_cnt;
        hold = 8'h00;
      end
      if (!rst_n) begin
        chk("rst_data", int'(data_out), 0);
        chk("rst_par", int'(parity), 0);
        chk("rst_valid", int'(valid), 0);
      end else begin
        chk("valid", int'(valid), int'(iss));
        if (iss) begin
          if (exp_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL sb_empty: got read, expected none queued");
          end else begin
            e = exp_q.pop_front();
            hold = e;
          end
        end
        chk("data", int'(data_out), int'(hold));
        chk("parity", int'(parity), int'(even_par(hold)));
      end
    end
  end

  task automatic cyc(input logic e, input logic [3:0] a);
    @(negedge clk);
    en   = e;
    addr = a;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_data", int'(data_out), 0);
    chk("async_par", int'(parity), 0);
    chk("async_valid", int'(valid), 0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    nchk  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    addr  = 4'h8;
    #1;
    chk("cold_data", int'(data_out), 0);
    chk("cold_valid", int'(valid), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;

    for (int i = 0; i < 16; i++) cyc(1'b1, 4'(i));

    cyc(1'b1, 4'h9);
    repeat (3) cyc(1'b0, 4'h3);
    cyc(1'b1, 4'h3);
    cyc(1'b0, 4'h0);

    for (int i = 0; i < 6; i++) cyc(1'b1, 4'(i));
    rst_pulse();
    cyc(1'b0, 4'h0);

    cyc(1'b1, 4'h1);
    @(negedge clk);
    addr = 4'hE;
    #1;
    chk("lat_hold", int'(data_out), 8'h02);
    cyc(1'b0, 4'h0);

    repeat (3) cyc(1'b1, 4'hD);
    cyc(1'b0, 4'h0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) rst_pulse();
      else cyc(1'($urandom_range(0, 3) != 0), 4'($urandom));
    end

    cyc(1'b0, 4'h0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
